// File: rtl/sine_rom_pkg.sv
// -----------------------------------------------------------------------------
// sine_rom_pkg
// Shared constants and types for the 64-word signed sine ROM.
//   SINE_ADDR_W / SINE_DATA_W / SINE_DEPTH : geometry of the full-period table
//   sine_sample_t : signed 32-bit two's-complement sample
//   sine_addr_t   : 6-bit word index into the full period
//   sine_qidx_t   : 5-bit index into the quarter-wave table (0..16)
// -----------------------------------------------------------------------------
package sine_rom_pkg;

    localparam int SINE_ADDR_W = 6;
    localparam int SINE_DATA_W = 32;
    localparam int SINE_DEPTH  = 64;
    localparam int SINE_QIDX_W = 5;

    typedef logic signed [SINE_DATA_W-1:0] sine_sample_t;
    typedef logic        [SINE_ADDR_W-1:0] sine_addr_t;
    typedef logic        [SINE_QIDX_W-1:0] sine_qidx_t;

endpackage

// File: rtl/sine_quarter_lut.sv
// -----------------------------------------------------------------------------
// sine_quarter_lut
// Combinational 17-entry first-quarter sine table:
//   sample = round((2^31-1) * sin(2*pi*idx/64)), idx = 0..16.
// Ports:
//   idx    : in  5-bit quarter index (0..16; larger values return 0)
//   sample : out signed 32-bit non-negative sample
// -----------------------------------------------------------------------------
module sine_quarter_lut
    import sine_rom_pkg::*;
(
    input  sine_qidx_t   idx,
    output sine_sample_t sample
);

    always_comb begin
        sample = '0;
        case (idx)
            5'd0:    sample = 32'sh0000_0000;
            5'd1:    sample = 32'sh0C8B_D35E;
            5'd2:    sample = 32'sh18F8_B83C;
            5'd3:    sample = 32'sh2528_0C5D;
            5'd4:    sample = 32'sh30FB_C54D;
            5'd5:    sample = 32'sh3C56_BA70;
            5'd6:    sample = 32'sh471C_ECE6;
            5'd7:    sample = 32'sh5133_CC94;
            5'd8:    sample = 32'sh5A82_7999;
            5'd9:    sample = 32'sh62F2_01AC;
            5'd10:   sample = 32'sh6A6D_98A3;
            5'd11:   sample = 32'sh70E2_CBC5;
            5'd12:   sample = 32'sh7641_AF3C;
            5'd13:   sample = 32'sh7A7D_055A;
            5'd14:   sample = 32'sh7D8A_5F3F;
            5'd15:   sample = 32'sh7F62_368E;
            5'd16:   sample = 32'sh7FFF_FFFF;
            default: sample = '0;
        endcase
    end

endmodule

// File: rtl/sine_rom64.sv
// -----------------------------------------------------------------------------
// sine_rom64
// Synchronous 64 x 32 read-only table holding one full period of a signed
// sine wave, built from a quarter-wave table plus quadrant folding.
// Ports:
//   clk     : in  system clock, rising edge
//   rst     : in  synchronous active-high reset; clears data (and valid)
//   address : in  6-bit word index 0..63
//   en      : in  read enable; data updates one clock after en=1
//   valid   : out en delayed one clock (only with SINE_ROM_VALID_EN defined)
//   data    : out registered signed sample, holds while en=0
// Build option: define SINE_ROM_VALID_EN to add the valid output.
// Only the default ADDR_WIDTH=6 / DATA_WIDTH=32 geometry is supported.
// -----------------------------------------------------------------------------
module sine_rom64
    import sine_rom_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic        [ADDR_WIDTH-1:0] address,
    input  logic                         en,
`ifdef SINE_ROM_VALID_EN
    output logic                         valid,
`endif
    output logic signed [DATA_WIDTH-1:0] data
);

    // Negation cannot overflow: the table magnitude never exceeds 2^31-1,
    // so 0x80000000 is never produced.
    function automatic sine_sample_t negate_sample(input sine_sample_t s);
        return -s;
    endfunction

    sine_addr_t   addr_p0;
    logic [1:0]   quad_p0;
    logic [3:0]   sub_p0;
    sine_qidx_t   qidx_p0;
    sine_sample_t mag_p0;
    sine_sample_t sample_p0;

    // Stage p0: quadrant folding onto the first quarter wave
    assign addr_p0 = address;
    assign quad_p0 = addr_p0[5:4];
    assign sub_p0  = addr_p0[3:0];

    // Quadrants 1 and 3 run the quarter wave backwards (sin(pi - x)).
    assign qidx_p0 = quad_p0[0] ? (5'd16 - {1'b0, sub_p0}) : {1'b0, sub_p0};

    sine_quarter_lut u_quarter_lut (
        .idx    (qidx_p0),
        .sample (mag_p0)
    );

    // Quadrants 2 and 3 are the negative half period.
    assign sample_p0 = quad_p0[1] ? negate_sample(mag_p0) : mag_p0;

    // Stage p1: registered output sample
    sine_sample_t data_p1 = '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_p1 <= '0;
        end else if (en) begin
            data_p1 <= sample_p0;
        end
    end

    assign data = data_p1;

`ifdef SINE_ROM_VALID_EN
    logic vld_p1 = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= en;
        end
    end

    assign valid = vld_p1;
`endif

endmodule

// File: tb/tb_sine_rom64.sv
// -----------------------------------------------------------------------------
// tb_sine_rom64
// Self-checking bench for sine_rom64. The reference table is computed from
// round((2^31-1)*sin(2*pi*k/64)); a cycle model tracks the registered output.
// Define SINE_ROM_VALID_EN to also exercise the valid output.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sine_rom64;

    localparam real PI = 3.14159265358979323846;

    logic               clk = 1'b0;
    logic               rst;
    logic        [5:0]  address;
    logic               en;
    logic signed [31:0] data;
`ifdef SINE_ROM_VALID_EN
    logic               valid;
`endif

    always #5 clk = ~clk;

    sine_rom64 dut (
        .clk     (clk),
        .rst     (rst),
        .address (address),
        .en      (en),
`ifdef SINE_ROM_VALID_EN
        .valid   (valid),
`endif
        .data    (data)
    );

    // Reference table
    logic [31:0] golden [64];
    bit          golden_ready = 1'b0;

    // Literal expectations requested by the stimulus process
    bit          lit_on = 1'b0;
    string       lit_name = "";
    logic [31:0] lit_want = '0;
    bit          vlit_on = 1'b0;
    logic        vlit_want = 1'b0;
    bit          done = 1'b0;

    // Cycle model of the registered outputs
    logic [31:0] exp_data = '0;
    logic        exp_valid = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    bit pins_done = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            exp_data  <= '0;
            exp_valid <= 1'b0;
        end else begin
            if (en) exp_data <= golden[address];
            exp_valid <= en;
        end
    end

    // Single compare process: model pins, per-cycle model check, literals
    always @(negedge clk) begin
        if (!pins_done && golden_ready) begin
            pins_done = 1'b1;
            vectors += 4;
            if (golden[16] !== 32'h7FFFFFFF) begin miscompares++; $display("FAIL model_k16: got %h want 7fffffff", golden[16]); end
            if (golden[48] !== 32'h80000001) begin miscompares++; $display("FAIL model_k48: got %h want 80000001", golden[48]); end
            if (golden[8]  !== 32'h5A827999) begin miscompares++; $display("FAIL model_k8: got %h want 5a827999", golden[8]); end
            if (golden[40] !== 32'hA57D8667) begin miscompares++; $display("FAIL model_k40: got %h want a57d8667", golden[40]); end
        end
        vectors++;
        if (data !== exp_data) begin
            miscompares++;
            $display("FAIL cycle_data t=%0t: data=%h expected=%h", $time, data, exp_data);
        end
`ifdef SINE_ROM_VALID_EN
        vectors++;
        if (valid !== exp_valid) begin
            miscompares++;
            $display("FAIL cycle_valid t=%0t: valid=%b expected=%b", $time, valid, exp_valid);
        end
        if (vlit_on) begin
            vectors++;
            if (valid !== vlit_want) begin
                miscompares++;
                $display("FAIL %s_valid: valid=%b expected=%b", lit_name, valid, vlit_want);
            end
        end
`endif
        if (lit_on) begin
            vectors++;
            if (data !== lit_want) begin
                miscompares++;
                $display("FAIL %s: data=%h expected=%h", lit_name, data, lit_want);
            end
        end
        if (done) begin
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    // Drive inputs just after a rising edge; the following falling edge checks.
    task automatic apply(input logic r, input logic e, input logic [5:0] a);
        rst     = r;
        en      = e;
        address = a;
        @(posedge clk);
        #2;
        lit_on  = 1'b0;
        vlit_on = 1'b0;
    endtask

    task automatic check_lit(input string name, input logic [31:0] want);
        lit_name = name;
        lit_want = want;
        lit_on   = 1'b1;
    endtask

    task automatic check_vld(input logic want);
        vlit_want = want;
        vlit_on   = 1'b1;
    endtask

    initial begin
        real r;
        real rr;
        rst     = 1'b0;
        en      = 1'b0;
        address = '0;
        for (int k = 0; k < 64; k++) begin
            r  = (2.0 ** 31 - 1.0) * $sin(2.0 * PI * k / 64.0);
            rr = (r >= 0.0) ? $floor(r + 0.5) : -$floor(-r + 0.5);
            golden[k] = 32'($rtoi(rr));
        end
        golden_ready = 1'b1;

        // Power-up value before any reset or read
        apply(1'b0, 1'b0, 6'd0);
        check_lit("power_up", 32'h0);

        // Reset overrides en
        apply(1'b1, 1'b1, 6'd16);
        check_lit("reset_c1", 32'h0);
        check_vld(1'b0);
        apply(1'b1, 1'b1, 6'd16);
        check_lit("reset_c2", 32'h0);
        check_vld(1'b0);

        // Single reads
        apply(1'b0, 1'b1, 6'd16);
        check_lit("read_16", 32'h7FFFFFFF);
        check_vld(1'b1);
        apply(1'b0, 1'b1, 6'd48);
        check_lit("read_48", 32'h80000001);
        apply(1'b0, 1'b1, 6'd8);
        check_lit("read_8", 32'h5A827999);
        apply(1'b0, 1'b1, 6'd24);
        check_lit("read_24", 32'h5A827999);
        apply(1'b0, 1'b1, 6'd40);
        check_lit("read_40", 32'hA57D8667);
        apply(1'b0, 1'b1, 6'd32);
        check_lit("read_32", 32'h0);

        // Hold while en=0
        apply(1'b0, 1'b1, 6'd16);
        check_lit("hold_load", 32'h7FFFFFFF);
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, 1'b0, 6'(i));
            check_lit("hold", 32'h7FFFFFFF);
            check_vld(1'b0);
        end

        // Back-to-back reads
        apply(1'b0, 1'b1, 6'd31);
        check_lit("b2b_31", 32'h0C8BD35E);
        apply(1'b0, 1'b1, 6'd32);
        check_lit("b2b_32", 32'h0);
        apply(1'b0, 1'b1, 6'd33);
        check_lit("b2b_33", 32'hF3742CA2);

        // Two-period sweep, 1-in-10 tick, reset once at address 20
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 64; k++) begin
                for (int t = 0; t < 10; t++) begin
                    if (t == 0 && p == 0 && k == 20) begin
                        apply(1'b1, 1'b1, 6'(k));
                        check_lit("sweep_reset", 32'h0);
                    end else if (t == 0) begin
                        apply(1'b0, 1'b1, 6'(k));
                        if (p == 1 && k == 0) check_lit("sweep_wrap", golden[0]);
                        else if (p == 0 && k == 21) check_lit("sweep_after_reset", 32'h70E2CBC5);
                        else check_lit("sweep", golden[k]);
                    end else begin
                        apply(1'b0, 1'b0, 6'(k));
                    end
                end
            end
        end

        // Randomized reads with occasional reset
        for (int i = 0; i < 1500; i++) begin
            apply(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                  6'($urandom_range(0, 63)));
        end

        apply(1'b0, 1'b0, 6'd0);
        done = 1'b1;
    end

endmodule
